// File: rtl/fpu_result_fifo.sv
// fpu_result_fifo
// ----------------------------------------------------------------------------
// Result buffer placed after the FPU stage. Every result is classified as it
// is pushed, and the class is stored next to the word. The FPU is never
// stalled. When the buffer is full and no pop happens in that cycle, the
// incoming result is discarded and the drop is latched in drop_sticky.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   in_valid     in_data holds a finished FPU result this cycle
//   in_data      32-bit result word {sign, exp[EXP_W], mant}
//   out_valid    head entry available (level != 0)
//   out_ready    consumer takes the head entry
//   out_data     head result word, 0 when empty
//   out_status   head class {neg, denorm, ovf, zero}, 0 when empty
//   level        current entry count, 0..DEPTH
//   full         level == DEPTH
//   drop_sticky  a result was discarded while full
//   clear_drop   clears drop_sticky (a new drop in the same cycle wins)
// ----------------------------------------------------------------------------
module fpu_result_fifo #(
  parameter  int DEPTH = 4,
  parameter  int EXP_W = 6,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [3:0]    out_status,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          drop_sticky,
  input  logic          clear_drop
);

  localparam int               MANT_W   = 31 - EXP_W;
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  // Entry layout: {status[3:0], data[31:0]}
  typedef struct packed {
    logic [3:0]  status;
    logic [31:0] data;
  } entry_t;

  // Storage has no reset. Its contents only reach the outputs while
  // level != 0, so stale words never show up.
  entry_t mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;
  logic          drop_q,   drop_d;

  logic          push, pop, drop_ev, empty;
  entry_t        wr_entry, head;

  // Class bits: [0] zero, [1] overflow (exp all ones), [2] denormal,
  // [3] sign. Sign is reported for zero results as well.
  function automatic logic [3:0] classify(input logic [31:0] w);
    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] m;
    logic [3:0]        s;
    e    = w[30 -: EXP_W];
    m    = w[MANT_W-1:0];
    s[0] = (e == '0) && (m == '0);
    s[1] = (e == EXP_ONES);
    s[2] = (e == '0) && (m != '0);
    s[3] = w[31];
    return s;
  endfunction

  assign empty    = (level_q == '0);
  assign full     = (level_q == FULL_LVL);
  assign pop      = !empty && out_ready;
  // When full, a push is allowed only because the pop in the same cycle
  // frees the head slot. The write goes to the tail slot, which is the
  // old head slot, and the read pointer moves forward in that edge.
  assign push     = in_valid && (!full || pop);
  assign drop_ev  = in_valid && full && !pop;

  assign wr_entry = '{status: classify(in_data), data: in_data};
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A set and a clear in the same cycle leave the flag set.
    drop_d = drop_ev || (drop_q && !clear_drop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // The head is read with zero latency. The output is gated by occupancy,
  // so a reset clears the outputs right away through level_q.
  assign out_valid   = !empty;
  assign out_data    = empty ? 32'h0 : head.data;
  assign out_status  = empty ? 4'h0  : head.status;
  assign level       = level_q;
  assign drop_sticky = drop_q;

endmodule

// File: tb/tb_fpu_result_fifo.sv
// Directed bench for fpu_result_fifo (DEPTH=4, EXP_W=6). A table of
// per-cycle vectors covers the main function. Hand-written sequences cover
// asynchronous reset in the middle of a cycle.
module tb_fpu_result_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        clear_drop = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_status;
  logic [2:0]  level;
  logic        full;
  logic        drop_sticky;

  int checks = 0;
  int errors = 0;

  fpu_result_fifo #(.DEPTH(4), .EXP_W(6)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_status(out_status),
    .level(level), .full(full),
    .drop_sticky(drop_sticky), .clear_drop(clear_drop)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        rdy;
    logic        clr;
    logic        ov;
    logic [31:0] od;
    logic [3:0]  os;
    logic [2:0]  lvl;
    logic        fl;
    logic        dr;
  } vec_t;

  localparam int NV = 29;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [31:0] od,
                         input logic [3:0] os, input logic [2:0] lvl,
                         input logic fl, input logic dr);
    chk({tag, " out_valid"},   36'(out_valid),   36'(ov));
    chk({tag, " out_data"},    36'(out_data),    36'(od));
    chk({tag, " out_status"},  36'(out_status),  36'(os));
    chk({tag, " level"},       36'(level),       36'(lvl));
    chk({tag, " full"},        36'(full),        36'(fl));
    chk({tag, " drop_sticky"}, 36'(drop_sticky), 36'(dr));
  endtask

  // Inputs change on the falling edge. Outputs are sampled 1 time unit
  // after the rising edge.
  task automatic step(input logic iv, input logic [31:0] id, input logic rdy, input logic clr);
    @(negedge clock);
    in_valid = iv; in_data = id; out_ready = rdy; clear_drop = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    @(negedge clock);
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_drop = 1'b0;
  endtask

  initial begin
    //           iv  id            rdy clr  ov  od            os     lvl fl dr
    vt[0]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b0000, 3'd0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 32'h3E000000, 1'b0, 1'b0, 1'b1, 32'h3E000000, 4'b0000, 3'd1, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'b0000, 3'd0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1, 32'h80000000, 4'b1001, 3'd1, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 32'h7E000000, 1'b0, 1'b0, 1'b1, 32'h80000000, 4'b1001, 3'd2, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h80000000, 4'b1001, 3'd3, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h7E000000, 4'b0010, 3'd2, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h00000001, 4'b0100, 3'd1, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'b0000, 3'd0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'b0000, 3'd0, 1'b0, 1'b0};
    // fill A..D, then E is dropped
    vt[10] = '{1'b1, 32'h02000001, 1'b0, 1'b0, 1'b1, 32'h02000001, 4'b0000, 3'd1, 1'b0, 1'b0};
    vt[11] = '{1'b1, 32'h04000002, 1'b0, 1'b0, 1'b1, 32'h02000001, 4'b0000, 3'd2, 1'b0, 1'b0};
    vt[12] = '{1'b1, 32'h06000003, 1'b0, 1'b0, 1'b1, 32'h02000001, 4'b0000, 3'd3, 1'b0, 1'b0};
    vt[13] = '{1'b1, 32'h08000004, 1'b0, 1'b0, 1'b1, 32'h02000001, 4'b0000, 3'd4, 1'b1, 1'b0};
    vt[14] = '{1'b1, 32'h0A000005, 1'b0, 1'b0, 1'b1, 32'h02000001, 4'b0000, 3'd4, 1'b1, 1'b1};
    vt[15] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 32'h02000001, 4'b0000, 3'd4, 1'b1, 1'b0};
    // full: push F..K while popping, across the pointer wrap
    vt[16] = '{1'b1, 32'h0C000006, 1'b1, 1'b0, 1'b1, 32'h04000002, 4'b0000, 3'd4, 1'b1, 1'b0};
    vt[17] = '{1'b1, 32'h0E000007, 1'b1, 1'b0, 1'b1, 32'h06000003, 4'b0000, 3'd4, 1'b1, 1'b0};
    vt[18] = '{1'b1, 32'h10000008, 1'b1, 1'b0, 1'b1, 32'h08000004, 4'b0000, 3'd4, 1'b1, 1'b0};
    vt[19] = '{1'b1, 32'h12000009, 1'b1, 1'b0, 1'b1, 32'h0C000006, 4'b0000, 3'd4, 1'b1, 1'b0};
    vt[20] = '{1'b1, 32'h1400000A, 1'b1, 1'b0, 1'b1, 32'h0E000007, 4'b0000, 3'd4, 1'b1, 1'b0};
    vt[21] = '{1'b1, 32'h1600000B, 1'b1, 1'b0, 1'b1, 32'h10000008, 4'b0000, 3'd4, 1'b1, 1'b0};
    // drop, then clear coinciding with a drop, then clear alone
    vt[22] = '{1'b1, 32'h18000000, 1'b0, 1'b0, 1'b1, 32'h10000008, 4'b0000, 3'd4, 1'b1, 1'b1};
    vt[23] = '{1'b1, 32'h1A000000, 1'b0, 1'b1, 1'b1, 32'h10000008, 4'b0000, 3'd4, 1'b1, 1'b1};
    vt[24] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1, 32'h10000008, 4'b0000, 3'd4, 1'b1, 1'b0};
    // drain I, J, K
    vt[25] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h12000009, 4'b0000, 3'd3, 1'b0, 1'b0};
    vt[26] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h1400000A, 4'b0000, 3'd2, 1'b0, 1'b0};
    vt[27] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h1600000B, 4'b0000, 3'd1, 1'b0, 1'b0};
    vt[28] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 4'b0000, 3'd0, 1'b0, 1'b0};

    // Reset state while reset is held
    #12;
    chk_all("reset", 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vt[i].iv, vt[i].id, vt[i].rdy, vt[i].clr);
      chk_all($sformatf("v%0d", i), vt[i].ov, vt[i].od, vt[i].os, vt[i].lvl, vt[i].fl, vt[i].dr);
    end

    // Async reset with 3 entries stored: outputs clear before the next edge
    step(1'b1, 32'h3E000000, 1'b0, 1'b0);
    step(1'b1, 32'h80000000, 1'b0, 1'b0);
    step(1'b1, 32'h7E000000, 1'b0, 1'b0);
    idle_inputs();
    chk_all("pre_rst3", 1'b1, 32'h3E000000, 4'b0000, 3'd3, 1'b0, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk_all("midrst3", 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    // First push after release behaves as a push into an empty buffer
    step(1'b1, 32'h00000001, 1'b0, 1'b0);
    chk_all("post_rst", 1'b1, 32'h00000001, 4'b0100, 3'd1, 1'b0, 1'b0);

    // Async reset with the buffer full and drop_sticky set
    step(1'b1, 32'h02000001, 1'b0, 1'b0);
    step(1'b1, 32'h04000002, 1'b0, 1'b0);
    step(1'b1, 32'h06000003, 1'b0, 1'b0);
    step(1'b1, 32'h08000004, 1'b0, 1'b0);
    idle_inputs();
    chk_all("pre_rstf", 1'b1, 32'h00000001, 4'b0100, 3'd4, 1'b1, 1'b1);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk_all("midrstf", 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk_all("rst_idle", 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
